// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between instruction fetch and load/store,
// with data priority bounded by a consecutive-grant streak so fetch latency stays limited.
module mem_arbiter #(
  parameter int BUS_WIDTH       = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [BUS_WIDTH-1:0]  if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [BUS_WIDTH-1:0]  d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [BUS_WIDTH-1:0]  d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic [BUS_WIDTH-1:0]  mem_rdata
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
  owner_t owner, owner_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic [BUS_WIDTH-1:0] if_hold, d_hold;
  logic if_win, d_win;
  // grants are gated by rstb so nothing reaches the memory while in reset
  always_comb begin
    if_win     = rstb && if_req && (!d_req || streak == SMAX);
    d_win      = rstb && d_req && !if_win;
    owner_nxt  = if_win ? OWN_IF : (d_win && !d_we) ? OWN_D : OWN_NONE;
    streak_nxt = (if_req && d_win) ? ((streak == SMAX) ? streak : streak + 1'b1) : '0;
  end
  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign mem_en    = if_win || d_win;
  assign mem_we    = d_win && d_we;
  assign mem_addr  = if_win ? if_addr : (d_win ? d_addr : '0);
  assign mem_wdata = d_win ? d_wdata : '0;
  assign if_rvalid = owner == OWN_IF;
  assign d_rvalid  = owner == OWN_D;
  // response data passes through in the rvalid cycle, then the hold register keeps it
  assign if_rdata  = if_rvalid ? mem_rdata : if_hold;
  assign d_rdata   = d_rvalid ? mem_rdata : d_hold;
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      owner   <= OWN_NONE;
      streak  <= '0;
      if_hold <= '0;
      d_hold  <= '0;
    end else begin
      owner  <= owner_nxt;
      streak <= streak_nxt;
      if (if_rvalid) if_hold <= mem_rdata;
      if (d_rvalid) d_hold <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a spec-level arbiter model.
module tb_mem_arbiter;
  localparam int MAX = 4;
  logic        clk = 1'b0;
  logic        rstb;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.BUS_WIDTH(32), .ADDR_WIDTH(32), .MAX_DATA_STREAK(MAX)) dut (
    .clk(clk), .rstb(rstb),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[7:0]];
    end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstb = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h10; d_addr = 32'h10; d_wdata = '0;
    repeat (2) cyc();
    @(negedge clk);
    checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=000000", {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data addr=%h wdata=%h if_rdata=%h d_rdata=%h exp=0", mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    cyc();
    rstb = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_gnt, d_gnt, mem_en} !== 3'b011) begin
      errors++; $display("FAIL reset_release_gnt got=%b exp=011", {if_gnt, d_gnt, mem_en});
    end
    cyc();
    if_req = 1'b0; d_req = 1'b0;
    cyc();
  endtask

  task automatic test_single_fetch;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({d_gnt, mem_we, mem_wdata} !== {2'b11, 32'hDEADBEEF}) begin
      errors++; $display("FAIL fetch_setup_store gnt=%b we=%b wdata=%h exp 1 1 deadbeef", d_gnt, mem_we, mem_wdata);
    end
    cyc();
    d_req = 1'b0; d_we = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    checks++;
    if ({if_gnt, mem_en, mem_we, d_rvalid, mem_addr} !== {4'b1100, 32'h10}) begin
      errors++; $display("FAIL fetch_grant got=%b addr=%h exp=1100 addr=10", {if_gnt, mem_en, mem_we, d_rvalid}, mem_addr);
    end
    cyc();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL fetch_resp rvalid=%b rdata=%h exp 1 deadbeef", if_rvalid, if_rdata);
    end
    repeat (4) cyc();
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL fetch_hold rvalid=%b rdata=%h exp 0 deadbeef", if_rvalid, if_rdata);
    end
    cyc();
  endtask

  task automatic test_fairness;
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({if_gnt, d_gnt} !== {(c % 5) == 4, (c % 5) != 4}) begin
        errors++; $display("FAIL fairness_c%0d if_gnt/d_gnt=%b exp=%b", c, {if_gnt, d_gnt}, {(c % 5) == 4, (c % 5) != 4});
      end
      cyc();
    end
    if_req = 1'b0; d_req = 1'b0;
    cyc();
  endtask

  task automatic test_store_load;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if ({d_gnt, mem_we} !== 2'b11) begin
      errors++; $display("FAIL store_grant got=%b exp=11", {d_gnt, mem_we});
    end
    cyc();
    d_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_gnt, d_rvalid, mem_we} !== 3'b100) begin
      errors++; $display("FAIL load_grant_no_store_rvalid got=%b exp=100", {d_gnt, d_rvalid, mem_we});
    end
    cyc();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'h12345678}) begin
      errors++; $display("FAIL load_resp rvalid=%b rdata=%h exp 1 12345678", d_rvalid, d_rdata);
    end
    cyc();
  endtask

  task automatic test_interleave;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hA5A50F0F;
    cyc();
    d_we = 1'b0; d_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL interleave_load_gnt got=%b exp=1", d_gnt);
    end
    cyc();
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h20;
    @(negedge clk);
    checks++;
    if ({d_rvalid, if_rvalid, if_gnt, d_rdata} !== {3'b101, 32'h12345678}) begin
      errors++; $display("FAIL interleave_t1 got=%b d_rdata=%h exp=101 12345678", {d_rvalid, if_rvalid, if_gnt}, d_rdata);
    end
    cyc();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_rvalid, if_rvalid, if_rdata, d_rdata} !== {2'b01, 32'hA5A50F0F, 32'h12345678}) begin
      errors++; $display("FAIL interleave_t2 got=%b if_rdata=%h d_rdata=%h exp=01 a5a50f0f 12345678", {d_rvalid, if_rvalid}, if_rdata, d_rdata);
    end
    cyc();
  endtask

  task automatic test_mid_reset;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL midrst_gnt got=%b exp=1", if_gnt);
    end
    cyc();
    if_req = 1'b0; rstb = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_gnt, mem_en, if_rdata} !== 35'h0) begin
      errors++; $display("FAIL midrst_drop got=%b if_rdata=%h exp=000 0", {if_rvalid, if_gnt, mem_en}, if_rdata);
    end
    cyc();
    rstb = 1'b1; if_req = 1'b1;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL midrst_regrant got=%b exp=1", if_gnt);
    end
    cyc();
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL midrst_resp rvalid=%b rdata=%h exp 1 deadbeef", if_rvalid, if_rdata);
    end
    cyc();
  endtask

  task automatic test_random;
    logic [31:0] addrs [3];
    logic [31:0] ref_mem [3];
    logic [31:0] pend_data, exp_if_rd, exp_d_rd, exp_addr, exp_wdata;
    int pend_owner, streak, win, if_idx, d_idx;
    addrs = '{32'h10, 32'h20, 32'h40};
    ref_mem = '{32'hDEADBEEF, 32'hA5A50F0F, 32'h12345678};
    pend_owner = 0; pend_data = '0; exp_if_rd = 32'hDEADBEEF; exp_d_rd = '0;
    streak = 0; if_idx = 0; d_idx = 0; win = 0;
    for (int n = 0; n < 400; n++) begin
      if (win == 1) if_req = 1'b0;
      if (win == 2) d_req = 1'b0;
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1; if_idx = int'($urandom_range(0, 2)); if_addr = addrs[if_idx];
      end
      if (!d_req && $urandom_range(0, 3) != 0) begin
        d_req = 1'b1; d_idx = int'($urandom_range(0, 2)); d_addr = addrs[d_idx];
        d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
      @(negedge clk);
      if (pend_owner == 1) exp_if_rd = pend_data;
      if (pend_owner == 2) exp_d_rd = pend_data;
      checks++;
      if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== {pend_owner == 1, pend_owner == 2, exp_if_rd, exp_d_rd}) begin
        errors++; $display("FAIL rand_resp n=%0d rv=%b if_rdata=%h d_rdata=%h exp rv=%b %h %h", n, {if_rvalid, d_rvalid},
                           if_rdata, d_rdata, {pend_owner == 1, pend_owner == 2}, exp_if_rd, exp_d_rd);
      end
      win = (if_req && (!d_req || streak == MAX)) ? 1 : (d_req ? 2 : 0);
      exp_addr = (win == 1) ? if_addr : (win == 2) ? d_addr : '0;
      exp_wdata = (win == 2) ? d_wdata : '0;
      checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
          {win == 1, win == 2, win != 0, win == 2 && d_we, exp_addr, exp_wdata}) begin
        errors++; $display("FAIL rand_grant n=%0d gnt/en/we=%b addr=%h wdata=%h exp %b %h %h", n,
                           {if_gnt, d_gnt, mem_en, mem_we}, mem_addr, mem_wdata,
                           {win == 1, win == 2, win != 0, win == 2 && d_we}, exp_addr, exp_wdata);
      end
      pend_owner = (win == 1) ? 1 : (win == 2 && !d_we) ? 2 : 0;
      pend_data = (win == 1) ? ref_mem[if_idx] : ref_mem[d_idx];
      if (win == 2 && d_we) ref_mem[d_idx] = d_wdata;
      streak = (if_req && win == 2) ? ((streak < MAX) ? streak + 1 : MAX) : 0;
      cyc();
    end
    if_req = 1'b0; d_req = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_fairness();
    test_store_load();
    test_interleave();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
